// File: rtl/timersoc_sevenseg_scan_if.sv
// Interface for the 2-digit seven-segment scanner.
//   value_in   : display value (GPIO out_port), low nibble -> digit 0
//   enable     : 1 = scan, 0 = display dark
//   hex_mode   : 1 = hex glyphs, 0 = BCD (nibbles > 9 show a dash)
//   lz_blank   : 1 = blank digit 1 when its nibble is zero
//   seg_n      : segments {g,f,e,d,c,b,a}, active-low
//   dig_n      : digit enables, active-low, bit0 = digit 0
//   frame_tick : one-cycle pulse when a new frame value is captured
// master drives the inputs; slave is the scanner.
interface timersoc_sevenseg_scan_if;
    logic [7:0] value_in;
    logic       enable;
    logic       hex_mode;
    logic       lz_blank;
    logic [6:0] seg_n;
    logic [1:0] dig_n;
    logic       frame_tick;

    modport master (
        output value_in, enable, hex_mode, lz_blank,
        input  seg_n, dig_n, frame_tick
    );

    modport slave (
        input  value_in, enable, hex_mode, lz_blank,
        output seg_n, dig_n, frame_tick
    );
endinterface

// File: rtl/timersoc_sevenseg_scan.sv
// Time-multiplexed 2-digit seven-segment driver.
// Each digit slot is CLK_DIV cycles: BLANK_CYCLES dark, then the digit driven.
// The value is captured into a shadow register only at frame start, so a
// frame never mixes two values.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous, active-low reset
//   bus     : scanner interface (slave modport), see timersoc_sevenseg_scan_if
//
// state | meaning
// IDLE  | display dark, waiting for enable
// BLANK | all digits off for BLANK_CYCLES cycles before driving a digit
// DRIVE | selected digit on for CLK_DIV-BLANK_CYCLES cycles
module timersoc_sevenseg_scan #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                          clk,
    input  logic                          reset_n,
    timersoc_sevenseg_scan_if.slave       bus
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - BLANK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          idx, idx_nx;
    logic [7:0]    shadow, shadow_nx;
    logic [6:0]    seg_q, seg_nx;
    logic [1:0]    dig_q, dig_nx;
    logic          tick_q, tick_nx;
    logic [3:0]    nibble;

    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] p;
        p = 7'h40;
        if (hex || nib <= 4'd9) begin
            case (nib)
                4'h0: p = 7'h3F;
                4'h1: p = 7'h06;
                4'h2: p = 7'h5B;
                4'h3: p = 7'h4F;
                4'h4: p = 7'h66;
                4'h5: p = 7'h6D;
                4'h6: p = 7'h7D;
                4'h7: p = 7'h07;
                4'h8: p = 7'h7F;
                4'h9: p = 7'h6F;
                4'hA: p = 7'h77;
                4'hB: p = 7'h7C;
                4'hC: p = 7'h39;
                4'hD: p = 7'h5E;
                4'hE: p = 7'h79;
                default: p = 7'h71;
            endcase
        end
        return p;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= 1'b0;
            shadow <= 8'h00;
            seg_q  <= 7'h7F;
            dig_q  <= 2'b11;
            tick_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            idx    <= idx_nx;
            shadow <= shadow_nx;
            seg_q  <= seg_nx;
            dig_q  <= dig_nx;
            tick_q <= tick_nx;
        end
    end

    // Outputs are computed from the post-transition values so the registered
    // outputs match the state being entered on the same edge.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        idx_nx    = idx;
        shadow_nx = shadow;
        tick_nx   = 1'b0;
        seg_nx    = 7'h7F;
        dig_nx    = 2'b11;

        if (!bus.enable) begin
            // Disable wins over a coincident wrap: no capture, no tick.
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx  = BLANK;
                    cnt_nx    = '0;
                    idx_nx    = 1'b0;
                    shadow_nx = bus.value_in;
                    tick_nx   = 1'b1;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nx = DRIVE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                        idx_nx   = ~idx;
                        if (idx) begin
                            shadow_nx = bus.value_in;
                            tick_nx   = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = 1'b0;
                end
            endcase
        end

        nibble = idx_nx ? shadow_nx[7:4] : shadow_nx[3:0];
        if (state_nx == DRIVE && !(bus.lz_blank && idx_nx && shadow_nx[7:4] == 4'h0)) begin
            dig_nx = ~(2'b01 << idx_nx);
            seg_nx = ~glyph(nibble, bus.hex_mode);
        end
    end

    assign bus.seg_n      = seg_q;
    assign bus.dig_n      = dig_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_timersoc_sevenseg_scan.sv
module tb_timersoc_sevenseg_scan;

    localparam int CD = 8;
    localparam int BL = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    timersoc_sevenseg_scan_if bus();

    timersoc_sevenseg_scan #(.CLK_DIV(CD), .BLANK_CYCLES(BL)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: position within the frame (-1 = idle) plus the shadow.
    int         m_pos;
    logic [7:0] m_shadow;
    logic [6:0] m_seg;
    logic [1:0] m_dig;
    logic       m_tick;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        logic [7:0] value;
        logic       hex;
        logic       lz;
        logic [6:0] seg0;
        logic [6:0] seg1;
        logic [1:0] dig1;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [6:0] ref_pattern(input logic [3:0] nib, input logic hex);
        if (!hex && nib > 4'd9) return 7'h40;
        return GLYPH[nib];
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos    = -1;
        m_shadow = 8'h00;
        m_seg    = 7'h7F;
        m_dig    = 2'b11;
        m_tick   = 1'b0;
    endtask

    task automatic model_update();
        int slot;
        int ph;
        logic [3:0] nib;
        if (!bus.enable) begin
            m_pos  = -1;
            m_tick = 1'b0;
        end else if (m_pos < 0 || m_pos == 2*CD-1) begin
            m_pos    = 0;
            m_shadow = bus.value_in;
            m_tick   = 1'b1;
        end else begin
            m_pos++;
            m_tick = 1'b0;
        end
        m_seg = 7'h7F;
        m_dig = 2'b11;
        if (m_pos >= 0) begin
            slot = m_pos / CD;
            ph   = m_pos % CD;
            nib  = (slot == 1) ? m_shadow[7:4] : m_shadow[3:0];
            if (ph >= BL && !(slot == 1 && bus.lz_blank && m_shadow[7:4] == 4'h0)) begin
                m_dig = (slot == 1) ? 2'b01 : 2'b10;
                m_seg = ~ref_pattern(nib, bus.hex_mode);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("scan_model", {6'b0, bus.seg_n, bus.dig_n, bus.frame_tick},
                            {6'b0, m_seg, m_dig, m_tick});
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic check_out(input string name, input logic [6:0] seg, input logic [1:0] dig);
        check(name, {7'b0, bus.seg_n, bus.dig_n}, {7'b0, seg, dig});
    endtask

    task automatic check_tick(input string name, input logic t);
        check(name, {15'b0, bus.frame_tick}, {15'b0, t});
    endtask

    task automatic go_idle();
        bus.enable = 1'b0;
        steps(2);
    endtask

    // Async reset placed between clock edges (called just after a step).
    task automatic pulse_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_out("reset_async_dark", 7'h7F, 2'b11);
        check_tick("reset_async_tick", 1'b0);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus.value_in = 8'h00;
        bus.enable   = 1'b0;
        bus.hex_mode = 1'b1;
        bus.lz_blank = 1'b0;
        model_reset();

        vecs[0] = '{8'h31, 1'b1, 1'b0, 7'h79, 7'h30, 2'b01};
        vecs[1] = '{8'h0C, 1'b0, 1'b1, 7'h3F, 7'h7F, 2'b11};
        vecs[2] = '{8'h0C, 1'b0, 1'b0, 7'h3F, 7'h40, 2'b01};
        vecs[3] = '{8'h00, 1'b1, 1'b1, 7'h40, 7'h7F, 2'b11};
        vecs[4] = '{8'h7A, 1'b1, 1'b0, 7'h08, 7'h78, 2'b01};
        vecs[5] = '{8'hAB, 1'b0, 1'b0, 7'h3F, 7'h3F, 2'b01};
        vecs[6] = '{8'h5F, 1'b1, 1'b1, 7'h0E, 7'h12, 2'b01};

        #12;
        check_out("reset_dark", 7'h7F, 2'b11);
        check_tick("reset_tick", 1'b0);
        #1;
        reset_n = 1'b1;

        // Idle after reset: stays dark, never ticks (model checks each cycle).
        steps(20);
        check_tick("idle_tick", 1'b0);

        // Table-driven frames.
        foreach (vecs[i]) begin
            go_idle();
            bus.value_in = vecs[i].value;
            bus.hex_mode = vecs[i].hex;
            bus.lz_blank = vecs[i].lz;
            bus.enable   = 1'b1;
            step();                                   // pos 0
            check_tick("tbl_first_tick", 1'b1);
            check_out("tbl_blank0", 7'h7F, 2'b11);
            steps(2);                                 // pos 2
            check_out("tbl_dig0_first", vecs[i].seg0, 2'b10);
            steps(5);                                 // pos 7
            check_out("tbl_dig0_last", vecs[i].seg0, 2'b10);
            step();                                   // pos 8
            check_out("tbl_blank1", 7'h7F, 2'b11);
            steps(2);                                 // pos 10
            check_out("tbl_dig1", vecs[i].seg1, vecs[i].dig1);
            steps(6);                                 // pos 16
            check_tick("tbl_next_tick", 1'b1);
        end

        // Tear-free update: value change mid-frame only shows next frame.
        go_idle();
        bus.value_in = 8'h31;
        bus.hex_mode = 1'b1;
        bus.lz_blank = 1'b0;
        bus.enable   = 1'b1;
        step();
        steps(3);                                     // pos 3, digit 0 driven
        bus.value_in = 8'h7A;
        steps(7);                                     // pos 10
        check_out("tear_dig1_old", 7'h30, 2'b01);
        steps(8);                                     // pos 18
        check_out("tear_dig0_new", 7'h08, 2'b10);
        steps(8);                                     // pos 26
        check_out("tear_dig1_new", 7'h78, 2'b01);

        // Disable on the 3rd DRIVE cycle, then re-enable with a fresh capture.
        go_idle();
        bus.value_in = 8'h31;
        bus.enable   = 1'b1;
        step();
        steps(4);                                     // pos 4 = 3rd drive cycle
        check_out("dis_before", 7'h79, 2'b10);
        bus.enable = 1'b0;
        step();
        check_out("dis_dark", 7'h7F, 2'b11);
        check_tick("dis_no_tick", 1'b0);
        bus.value_in = 8'h5F;
        bus.enable   = 1'b1;
        step();
        check_tick("reen_tick", 1'b1);
        check_out("reen_blank", 7'h7F, 2'b11);
        steps(2);
        check_out("reen_fresh", 7'h0E, 2'b10);

        // Reset while scanning, then release with enable low.
        steps(1);
        pulse_reset();
        bus.enable = 1'b0;
        steps(20);
        check_tick("post_reset_idle_tick", 1'b0);

        // Randomized run against the model.
        for (int n = 0; n < 1500; n++) begin
            bus.enable = ($urandom % 16) != 0;
            if ($urandom % 4 == 0) bus.value_in = 8'($urandom);
            if ($urandom % 32 == 0) bus.hex_mode = ~bus.hex_mode;
            if ($urandom % 32 == 0) bus.lz_blank = ~bus.lz_blank;
            step();
            if ($urandom % 150 == 0) pulse_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timersoc_sevenseg_scan.md
Name: timersoc_sevenseg_scan

Overview:
- Time-multiplexed 2-digit seven-segment driver. It consumes the 8-bit out_port of the GPIO output PIO as value_in and drives one shared segment bus plus two digit enables.
- Low nibble is shown on digit 0 (right); high nibble on digit 1 (left).
- Each digit slot has a blanking interval, which suppresses ghosting.
- The displayed value is captured only at frame start, so a digit never tears mid-frame.

Parameters:
CLK_DIV, 50000, clk cycles per digit slot (blank + drive); legal: CLK_DIV > BLANK_CYCLES
BLANK_CYCLES, 500, cycles per slot with all digits off; legal: >= 1

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
value_in  input  8  display value from GPIO output PIO out_port
enable  input  1  1 = scan; 0 = display dark
hex_mode  input  1  1 = nibbles 0-F as hex glyphs; 0 = BCD, nibbles >9 show dash
lz_blank  input  1  1 = blank digit 1 when high nibble is 0
seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low
dig_n  output  2  digit enables, active-low, bit0 = digit 0
frame_tick  output  1  one-cycle pulse when a new frame value is captured

Behaviour:
- Clock and reset: reset reset_n, asynchronous, active-low; clock clk. All outputs are registered.
- Reset values: seg_n=7'h7F, dig_n=2'b11, frame_tick=0, state=IDLE, digit index=0, slot counter=0, shadow=0.
- States:
  - IDLE: outputs dark.
  - BLANK: dig_n=11, seg_n=7F, counter counts 0..BLANK_CYCLES-1.
  - DRIVE: selected digit on, counter counts 0..CLK_DIV-BLANK_CYCLES-1.
- IDLE -> BLANK: on the edge where enable=1.
  - Digit index <= 0, counter <= 0, shadow <= value_in.
  - frame_tick=1 for that one cycle.
- BLANK -> DRIVE: when counter == BLANK_CYCLES-1. Counter <= 0, same digit.
- DRIVE -> BLANK: when counter == CLK_DIV-BLANK_CYCLES-1. Digit index toggles.
  - If the new index is 0 (wrap): shadow <= value_in and frame_tick pulses one cycle.
- enable=0 in any state: next edge goes to IDLE and outputs go dark. Counter and index clear; shadow is retained.
- Output timing: registered outputs reflect the state entered, in the same cycle as the transition edge. A DRIVE slot therefore shows the digit for exactly CLK_DIV-BLANK_CYCLES cycles. A full frame is 2*CLK_DIV cycles.
- Digit drive: dig_n = ~(1 << index).
- Glyph (active-high pattern; seg_n = ~pattern):
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - dash: 40
- BCD mode: when hex_mode=0 and nibble >9, the pattern is dash.
- Leading-zero blank: when lz_blank=1, shadow[7:4]==0 and index==1 in DRIVE, then seg_n=7F and dig_n=11. Timing is unchanged.
  - Digit 0 is never blanked: value 0x00 shows "0".
- Live vs. frozen inputs:
  - hex_mode and lz_blank are applied combinationally to the current shadow and take effect at the next register update.
  - value_in changes mid-frame are ignored until the next frame capture.
- Simultaneous events: enable falling on the same edge as a wrap goes to IDLE with no capture and no frame_tick.
- Reset mid-operation: immediately forces the reset values.
- Counter width: $clog2(CLK_DIV); there are no other arithmetic paths.

Test Plan:
All tests use CLK_DIV=8, BLANK_CYCLES=2.
1. Reset and idle: assert reset_n=0 during scanning -> seg_n=7F, dig_n=11 immediately. Release with enable=0 -> outputs stay dark and frame_tick=0 indefinitely.
2. Basic scan: value_in=8'h31, hex_mode=1, enable=1 ->
   - frame_tick pulses on the first edge.
   - 2 cycles dark, then 6 cycles dig_n=10, seg_n=79 ("1").
   - 2 cycles dark, then 6 cycles dig_n=01, seg_n=30 ("3").
   - Next frame_tick occurs 16 cycles after the first.
3. Tear-free update: change value_in 31->7A while digit 0 is driven -> digit 1 still shows "3" (30) this frame. Next frame shows "A" (08) on digit 0 and "7" (78) on digit 1.
4. BCD and leading-zero blank: value_in=8'h0C, hex_mode=0, lz_blank=1 -> digit 0 shows dash (seg_n=3F); digit 1 slot fully dark for 6 cycles. With lz_blank=0 -> digit 1 shows "0" (40).
5. Disable mid-slot: drop enable on the 3rd DRIVE cycle -> dark on the next edge, no frame_tick. Re-enable -> restarts at digit 0 BLANK with frame_tick and a fresh capture.
6. Zero value: value_in=00, lz_blank=1 -> digit 0 shows "0" (seg_n=40); digit 1 dark.
